// File: rtl/bus_cycle_pkg.sv
// Shared types and default region map for the bus-cycle controller.
// Bus states are one-hot; region bases and masks are packed with element 0 in the rightmost slice.
package bus_cycle_pkg;

   typedef enum logic [4:0] {
      T1 = 5'b00001,
      T2 = 5'b00010,
      T3 = 5'b00100,
      TW = 5'b01000,
      T4 = 5'b10000
   } state_t;

   typedef enum logic {
      CYC_RD = 1'b0,
      CYC_WR = 1'b1
   } cycle_t;

   localparam int DEF_ADDR_W = 20;
   localparam int DEF_N_MEM  = 2;
   localparam int DEF_N_IO   = 2;
   localparam int NCS        = DEF_N_MEM + DEF_N_IO;

   localparam logic [DEF_N_MEM*DEF_ADDR_W-1:0] DEF_MEM_BASE = {20'h00000, 20'h80000};
   localparam logic [DEF_N_MEM*DEF_ADDR_W-1:0] DEF_MEM_MASK = {20'h80000, 20'h80000};
   localparam logic [DEF_N_IO*DEF_ADDR_W-1:0]  DEF_IO_BASE  = {20'h01C00, 20'h0FF00};
   localparam logic [DEF_N_IO*DEF_ADDR_W-1:0]  DEF_IO_MASK  = {20'h0FE00, 20'h0FFF0};

endpackage

// File: rtl/bus_cycle_ctrl_cs_decode.sv
// Combinational region decoder: active-low one-hot select, lowest matching index wins.
// With en low every select is inactive and miss stays low.
module cs_decode #(
   parameter int                  ADDR_W = 20,
   parameter int                  N      = 2,
   parameter logic [N*ADDR_W-1:0] BASE   = '0,
   parameter logic [N*ADDR_W-1:0] MASK   = '0
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              en,
   output logic [N-1:0]      cs,
   output logic              miss
);

   logic hit;

   // NOTE: every output gets a default before the loop so no path leaves a latch.
   always_comb begin
      cs   = '1;
      hit  = 1'b0;
      miss = 1'b0;
      if (en) begin
         for (int i = 0; i < N; i++) begin
            if (!hit && ((addr & MASK[i*ADDR_W +: ADDR_W]) ==
                         (BASE[i*ADDR_W +: ADDR_W] & MASK[i*ADDR_W +: ADDR_W]))) begin
               cs[i] = 1'b0;
               hit   = 1'b1;
            end
         end
         miss = !hit;
      end
   end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 8088-style bus-cycle sequencer: T1/T2/T3/TW/T4 with wait states, READY stretch,
// registered OE/WD strobes and chip selects decoded from the address latched on ALE.
module bus_cycle_ctrl
   import bus_cycle_pkg::*;
#(
   parameter int                        ADDR_W     = DEF_ADDR_W,
   parameter int                        N_MEM      = DEF_N_MEM,
   parameter int                        N_IO       = DEF_N_IO,
   parameter logic [N_MEM*ADDR_W-1:0]   MEM_BASE   = DEF_MEM_BASE,
   parameter logic [N_MEM*ADDR_W-1:0]   MEM_MASK   = DEF_MEM_MASK,
   parameter logic [N_IO*ADDR_W-1:0]    IO_BASE    = DEF_IO_BASE,
   parameter logic [N_IO*ADDR_W-1:0]    IO_MASK    = DEF_IO_MASK,
   parameter int                        WAIT_W     = 3,
   parameter int                        MEM_WAIT   = 0,
   parameter int                        IO_WAIT    = 1,
   parameter int                        T2_TIMEOUT = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_W-1:0]       Address,
   input  logic                    IOM,
   input  logic                    RD,
   input  logic                    WR,
   input  logic                    ALE,
   input  logic                    READY,
   output logic                    OE,
   output logic                    WD,
   output logic [N_MEM+N_IO-1:0]   CS,
   output logic                    busy,
   output logic                    miss,
   output logic                    err
);

   localparam int TMO_W = $clog2(T2_TIMEOUT + 1);

   state_t              state;
   cycle_t              cyc_q;
   logic [ADDR_W-1:0]   a_q;
   logic                iom_q;
   logic [WAIT_W-1:0]   wait_q;
   logic [TMO_W-1:0]    tmo_q;

   logic [N_MEM-1:0]    mem_cs;
   logic [N_IO-1:0]     io_cs;
   logic                mem_miss;
   logic                io_miss;

   // NOTE: all sequential state uses non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= T1;
         cyc_q  <= CYC_RD;
         a_q    <= '0;
         iom_q  <= 1'b0;
         wait_q <= '0;
         tmo_q  <= '0;
         OE     <= 1'b1;
         WD     <= 1'b1;
         err    <= 1'b0;
      end else begin
         err <= 1'b0;
         unique case (state)
            T1: begin
               tmo_q <= '0;
               if (ALE) begin
                  a_q   <= Address;
                  iom_q <= IOM;
                  state <= T2;
               end
            end
            T2: begin
               if (!RD || !WR) begin
                  // RD wins when both strobes are low; the overlap itself is flagged
                  cyc_q  <= RD ? CYC_WR : CYC_RD;
                  OE     <= RD;
                  WD     <= !RD | WR;
                  err    <= !RD && !WR;
                  wait_q <= iom_q ? WAIT_W'(IO_WAIT) : WAIT_W'(MEM_WAIT);
                  tmo_q  <= '0;
                  state  <= T3;
               end else if (tmo_q == TMO_W'(T2_TIMEOUT - 1)) begin
                  tmo_q <= '0;
                  err   <= 1'b1;
                  state <= T1;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            T3, TW: begin
               if (wait_q != '0) begin
                  wait_q <= wait_q - WAIT_W'(1);
                  state  <= TW;
               end else if (READY) begin
                  OE    <= 1'b1;
                  WD    <= 1'b1;
                  state <= T4;
               end else begin
                  OE    <= (cyc_q != CYC_RD);
                  WD    <= (cyc_q != CYC_WR);
                  state <= TW;
               end
            end
            T4: begin
               tmo_q <= '0;
               if (ALE) begin
                  a_q   <= Address;
                  iom_q <= IOM;
                  state <= T2;
               end else begin
                  state <= T1;
               end
            end
            default: begin
               OE    <= 1'b1;
               WD    <= 1'b1;
               state <= T1;
            end
         endcase
      end
   end

   assign busy = (state != T1);

   cs_decode #(
      .ADDR_W (ADDR_W),
      .N      (N_MEM),
      .BASE   (MEM_BASE),
      .MASK   (MEM_MASK)
   ) u_mem_decode (
      .addr (a_q),
      .en   (busy && !iom_q),
      .cs   (mem_cs),
      .miss (mem_miss)
   );

   cs_decode #(
      .ADDR_W (ADDR_W),
      .N      (N_IO),
      .BASE   (IO_BASE),
      .MASK   (IO_MASK)
   ) u_io_decode (
      .addr (a_q),
      .en   (busy && iom_q),
      .cs   (io_cs),
      .miss (io_miss)
   );

   assign CS   = {io_cs, mem_cs};
   assign miss = iom_q ? io_miss : mem_miss;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Randomised transaction-level bench for bus_cycle_ctrl: each bus cycle is expanded
// into a per-clock list of expected outputs, compared every clock by one process.
module tb_bus_cycle_ctrl;
   import bus_cycle_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic [19:0]     Address;
   logic            IOM;
   logic            RD;
   logic            WR;
   logic            ALE;
   logic            READY;
   logic            OE;
   logic            WD;
   logic [NCS-1:0]  CS;
   logic            busy;
   logic            miss;
   logic            err;

   bus_cycle_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .Address (Address),
      .IOM     (IOM),
      .RD      (RD),
      .WR      (WR),
      .ALE     (ALE),
      .READY   (READY),
      .OE      (OE),
      .WD      (WD),
      .CS      (CS),
      .busy    (busy),
      .miss    (miss),
      .err     (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       oe;
      logic       wd;
      logic [3:0] cs;
      logic       busy;
      logic       miss;
      logic       err;
   } exp_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_cur;
   bit   exp_valid = 1'b0;

   int         oe_low_cnt = 0;
   int         wd_low_cnt = 0;
   int         busy_cnt   = 0;
   int         miss_cnt   = 0;
   int         err_cnt    = 0;
   logic [3:0] cs_seen    = 4'hF;
   int s_oe, s_wd, s_busy, s_miss, s_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
      end
   endtask

   // Reference decode written straight from the region table
   function automatic void decode(input logic [19:0] a, input bit io,
                                  output logic [3:0] cs, output bit m);
      logic [19:0] base [2];
      logic [19:0] mask [2];
      if (io) begin
         base[0] = 20'h0FF00; mask[0] = 20'h0FFF0;
         base[1] = 20'h01C00; mask[1] = 20'h0FE00;
      end else begin
         base[0] = 20'h80000; mask[0] = 20'h80000;
         base[1] = 20'h00000; mask[1] = 20'h80000;
      end
      cs = 4'hF;
      m  = 1'b1;
      for (int i = 1; i >= 0; i--) begin
         if ((a & mask[i]) == (base[i] & mask[i])) begin
            cs = 4'hF;
            cs[(io ? 2 : 0) + i] = 1'b0;
            m = 1'b0;
         end
      end
   endfunction

   function automatic exp_t bus_exp(input logic [19:0] a, input bit io,
                                    input logic oe, input logic wd, input logic e);
      exp_t r;
      logic [3:0] cs;
      bit m;
      decode(a, io, cs, m);
      r.oe = oe; r.wd = wd; r.cs = cs; r.busy = 1'b1; r.miss = m; r.err = e;
      return r;
   endfunction

   function automatic exp_t idle_exp(input logic e);
      exp_t r;
      r.oe = 1'b1; r.wd = 1'b1; r.cs = 4'hF; r.busy = 1'b0; r.miss = 1'b0; r.err = e;
      return r;
   endfunction

   function automatic logic [19:0] rnd_addr();
      logic [19:0] r;
      r = 20'($urandom);
      case ($urandom_range(0, 3))
         0: ;
         1: r = 20'h0FF00 | (r & 20'h0000F);
         2: r = 20'h01C00 | (r & 20'h001FF);
         default: r = r | 20'h80000;
      endcase
      return r;
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock: drive inputs, state what the outputs must be after the next edge
   task automatic step(input logic ale, input logic [19:0] a, input logic io,
                       input logic rd, input logic wr, input logic rdy, input exp_t e);
      ALE = ale; Address = a; IOM = io; RD = rd; WR = wr; READY = rdy;
      exp_cur   = e;
      exp_valid = 1'b1;
      @(negedge clk);
   endtask

   // kind: 0 read, 1 write, 2 both strobes. Ends with the DUT in T4.
   task automatic run_txn(input logic [19:0] a, input bit io, input int idle,
                          input int kind, input int rlow);
      int   w;
      logic rd_pin, wr_pin, oe_x, wd_x;
      w      = io ? 1 : 0;
      rd_pin = (kind == 1);
      wr_pin = (kind == 0);
      oe_x   = (kind == 1);
      wd_x   = (kind != 1);
      step(1'b1, a, io, 1'b1, 1'b1, rbit(), bus_exp(a, io, 1'b1, 1'b1, 1'b0));
      for (int i = 0; i < idle; i++)
         step(1'b0, rnd_addr(), rbit(), 1'b1, 1'b1, rbit(), bus_exp(a, io, 1'b1, 1'b1, 1'b0));
      step(1'b0, rnd_addr(), rbit(), rd_pin, wr_pin, rbit(),
           bus_exp(a, io, oe_x, wd_x, kind == 2));
      for (int i = 0; i < w + rlow; i++)
         step(1'b0, rnd_addr(), rbit(), rd_pin, wr_pin, (i < w) ? rbit() : 1'b0,
              bus_exp(a, io, oe_x, wd_x, 1'b0));
      step(1'b0, rnd_addr(), rbit(), rd_pin, wr_pin, 1'b1, bus_exp(a, io, 1'b1, 1'b1, 1'b0));
   endtask

   // Starts in T1 or T4, ends in T1 with the timeout error reported
   task automatic run_timeout(input logic [19:0] a, input bit io);
      step(1'b1, a, io, 1'b1, 1'b1, rbit(), bus_exp(a, io, 1'b1, 1'b1, 1'b0));
      for (int i = 1; i < 8; i++)
         step(1'b0, rnd_addr(), rbit(), 1'b1, 1'b1, rbit(), bus_exp(a, io, 1'b1, 1'b1, 1'b0));
      step(1'b0, rnd_addr(), rbit(), 1'b1, 1'b1, rbit(), idle_exp(1'b1));
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, rnd_addr(), rbit(), 1'b1, 1'b1, rbit(), idle_exp(1'b0));
   endtask

   task automatic snap();
      s_oe = oe_low_cnt; s_wd = wd_low_cnt; s_busy = busy_cnt;
      s_miss = miss_cnt; s_err = err_cnt;
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_valid) begin
         check("cycle {OE,WD,CS,busy,miss,err}", 32'({OE, WD, CS, busy, miss, err}), 32'(exp_cur));
         if (!OE) oe_low_cnt++;
         if (!WD) wd_low_cnt++;
         if (busy) busy_cnt++;
         if (miss) miss_cnt++;
         if (err) err_cnt++;
         if (!OE || !WD) cs_seen = CS;
      end
   end

   initial begin
      ALE = 1'b0; Address = '0; IOM = 1'b0; RD = 1'b1; WR = 1'b1; READY = 1'b1;
      rst = 1'b1;
      #1;
      check("reset_outputs", 32'({OE, WD, CS, busy, miss, err}), 32'(9'b11_1111_000));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle_steps(2);

      // memory read, zero waits
      snap();
      run_txn(20'h80010, 1'b0, 0, 0, 0);
      idle_steps(1);
      check("memrd_oe_cycles", 32'(oe_low_cnt - s_oe), 32'd1);
      check("memrd_wd_cycles", 32'(wd_low_cnt - s_wd), 32'd0);
      check("memrd_cs", 32'(cs_seen), 32'h0000000E);
      check("memrd_busy_cycles", 32'(busy_cnt - s_busy), 32'd3);

      // IO write with one wait state
      snap();
      run_txn(20'h0FF05, 1'b1, 1, 1, 0);
      idle_steps(1);
      check("iowr_wd_cycles", 32'(wd_low_cnt - s_wd), 32'd2);
      check("iowr_oe_cycles", 32'(oe_low_cnt - s_oe), 32'd0);
      check("iowr_cs", 32'(cs_seen), 32'h0000000B);

      // IO read stretched by READY
      snap();
      run_txn(20'h01C00, 1'b1, 0, 0, 3);
      idle_steps(1);
      check("iord_ready_oe_cycles", 32'(oe_low_cnt - s_oe), 32'd5);
      check("iord_ready_cs", 32'(cs_seen), 32'h00000007);

      // unmapped IO address
      snap();
      run_txn(20'h00010, 1'b1, 0, 0, 0);
      idle_steps(1);
      check("unmapped_cs", 32'(cs_seen), 32'h0000000F);
      check("unmapped_miss_cycles", 32'(miss_cnt - s_miss), 32'd4);
      check("unmapped_busy_cycles", 32'(busy_cnt - s_busy), 32'd4);

      // both strobes low together
      snap();
      run_txn(20'h00020, 1'b0, 2, 2, 1);
      idle_steps(1);
      check("both_err_cycles", 32'(err_cnt - s_err), 32'd1);
      check("both_oe_cycles", 32'(oe_low_cnt - s_oe), 32'd2);
      check("both_wd_cycles", 32'(wd_low_cnt - s_wd), 32'd0);

      // strobe timeout
      snap();
      run_timeout(20'h80000, 1'b0);
      idle_steps(1);
      check("timeout_err_cycles", 32'(err_cnt - s_err), 32'd1);
      check("timeout_busy_cycles", 32'(busy_cnt - s_busy), 32'd8);

      // strobe on the last T2 before the timeout still runs a cycle
      snap();
      run_txn(20'h80004, 1'b0, 7, 1, 0);
      idle_steps(1);
      check("late_strobe_err", 32'(err_cnt - s_err), 32'd0);
      check("late_strobe_wd_cycles", 32'(wd_low_cnt - s_wd), 32'd1);

      // back-to-back: ALE in T4 goes straight to T2 with the new address
      run_txn(20'h80000, 1'b0, 0, 0, 0);
      run_txn(20'h0FF00, 1'b1, 0, 0, 0);
      check("b2b_second_cs", 32'(cs_seen), 32'h0000000B);
      idle_steps(1);

      // asynchronous reset while in TW
      step(1'b1, 20'h01C00, 1'b1, 1'b1, 1'b1, 1'b1, bus_exp(20'h01C00, 1'b1, 1'b1, 1'b1, 1'b0));
      step(1'b0, 20'h0, 1'b0, 1'b0, 1'b1, 1'b0, bus_exp(20'h01C00, 1'b1, 1'b0, 1'b1, 1'b0));
      step(1'b0, 20'h0, 1'b0, 1'b0, 1'b1, 1'b0, bus_exp(20'h01C00, 1'b1, 1'b0, 1'b1, 1'b0));
      step(1'b0, 20'h0, 1'b0, 1'b0, 1'b1, 1'b0, bus_exp(20'h01C00, 1'b1, 1'b0, 1'b1, 1'b0));
      exp_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("rst_tw_oe", 32'(OE), 32'd1);
      check("rst_tw_cs", 32'(CS), 32'h0000000F);
      check("rst_tw_all", 32'({OE, WD, CS, busy, miss, err}), 32'(9'b11_1111_000));
      @(negedge clk);
      rst = 1'b0;
      RD = 1'b1;
      idle_steps(2);

      // randomised traffic
      for (int t = 0; t < 200; t++) begin
         if ($urandom_range(0, 9) == 0) begin
            run_timeout(rnd_addr(), rbit());
            idle_steps($urandom_range(0, 2));
         end else begin
            run_txn(rnd_addr(), rbit(), $urandom_range(0, 7), $urandom_range(0, 2),
                    $urandom_range(0, 4));
            if (rbit()) idle_steps($urandom_range(1, 3));
         end
      end
      idle_steps(2);
      exp_valid = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
